batchnorm_stream: RTL and testbench
===================================

# batchnorm_stream

Per-channel fixed-point affine normalisation, y = act(x·gamma + beta), on a valid/ready stream. It is the parametrised successor of the final-layer batchnorm stage and adds four things:
- runtime parameter writes;
- full backpressure;
- rounding;
- fused ReLU/ReLU6 activation.

It sits between the last convolution accumulator and the classifier. Channel tags travel with the data.

## Interface
Parameters:
- WIDTH, 16: data and parameter width, signed two's complement.
- FRAC, 8: fractional bits of x, gamma, beta and y. Range 1..WIDTH-2.
- CHANNELS, 48: number of channels. CW = max(1, $clog2(CHANNELS)).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input sample valid
- in_ready  out  1  block accepts the sample this cycle
- in_data  in  WIDTH  signed sample x
- in_ch  in  CW  channel tag of x
- in_act  in  2  activation for this sample: 0 none, 1 ReLU, 2 ReLU6, 3 treated as none
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts
- out_data  out  WIDTH  signed result y
- out_ch  out  CW  channel tag of y
- cfg_we  in  1  parameter write strobe
- cfg_sel  in  1  0 selects gamma, 1 selects beta
- cfg_ch  in  CW  channel to write
- cfg_wdata  in  WIDTH  value to write
- cfg_ready  out  1  write accepted (high in RUN)
- err_ch  out  1  sticky; set when an out-of-range channel is seen

## Operation
State machine, INIT then RUN:
- rst enters INIT with init counter = 0.
- Each INIT cycle writes gamma[cnt] = 1<<FRAC and beta[cnt] = 0, then increments the counter.
- After writing CHANNELS-1, the block moves to RUN. INIT lasts exactly CHANNELS cycles.
- in_ready and cfg_ready are 0 in INIT. cfg_we is ignored in INIT.
- rst asserted at any time, including mid-stream, discards all in-flight samples and restarts INIT.

Parameter writes:
- Applied in RUN when cfg_we=1.
- A write with cfg_ch >= CHANNELS is ignored and sets err_ch.

Transfers:
- An input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.

Pipeline, 3 stages; all stages advance together when adv = !out_valid || out_ready:
- S1 captures x, channel, act and reads gamma[ch] and beta[ch].
  - Read-before-write: a sample accepted in the same cycle as a cfg write to its channel uses the old value.
  - If in_ch >= CHANNELS, S1 uses gamma = 1<<FRAC and beta = 0, forces the output channel tag to 0, and sets err_ch. The sample is still emitted.
- S2: prod = x*gamma, full 2·WIDTH signed.
- S3, the output register:
  - r = (prod + 2^(FRAC-1)) >>> FRAC, arithmetic shift, round-half-up.
  - s = r + sign-extended beta, computed in 2·WIDTH+1 bits.
  - Saturate s to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - ReLU: negative results become 0.
  - ReLU6: clamp to [0, min(6<<FRAC, 2^(WIDTH-1)-1)].
- in_ready = (state == RUN) && adv. No bubble insertion, so throughput is 1 sample/cycle with out_ready held high.
- Stage valids shift with adv; holes in the input stream propagate as bubbles.

## Timing
Reset values:
- in_ready=0, out_valid=0, out_data=0, out_ch=0, cfg_ready=0, err_ch=0.
- All stage valids are 0.

Latency and stall:
- A sample accepted at cycle t appears at out_valid at t+3 when out_ready stays high.
- While out_valid && !out_ready, out_data and out_ch hold stable, all stages freeze and in_ready=0.
- No sample is lost or duplicated under arbitrary out_ready patterns.

Configuration and errors:
- A cfg write at cycle t affects samples accepted at t+1 or later.
- err_ch clears only on rst.

## Test plan
All values use FRAC=8.
- Reset: INIT lasts 48 cycles with in_ready=0. Then x=0x0300 on ch 5 with no writes -> y=0x0300 (unity gamma, zero beta).
- Affine + rounding:
  - gamma[2]=0x0180, beta[2]=0x0080, x=0x0200, ch 2 -> 0x0380 at t+3.
  - gamma=0x0080, x=0x0001 -> 0x0001.
  - gamma=0x0080, x=0xFFFF -> 0x0000.
- Saturation/activation:
  - x=0x7000, gamma=0x0400 -> 0x7FFF; x=0x9000, gamma=0x0400 -> 0x8000.
  - x=0xFF00 with ReLU -> 0x0000; x=0x0800 with ReLU6 -> 0x0600.
- Backpressure: a 100-sample stream under random out_ready matches the model in order with correct channel tags. out_data stays stable while stalled.
- Write collision: write gamma[7]=0x0200 in the same cycle a sample x=0x0100 on ch 7 is accepted -> 0x0100. The next ch 7 sample -> 0x0200.
- Errors/reset: in_ch=50 -> y=x, out_ch=0, err_ch=1. rst asserted with 3 samples in flight -> out_valid=0 next cycle and the block re-enters INIT.

Source files
------------

// File: rtl/batchnorm_stream.sv
// rtl/batchnorm_stream.sv - per-channel affine normalisation with rounding, saturation and fused ReLU/ReLU6
module batchnorm_stream #(
  parameter int WIDTH    = 16,
  parameter int FRAC     = 8,
  parameter int CHANNELS = 48,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CW-1:0]    in_ch,
  input  logic [1:0]       in_act,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_ch,
  input  logic             cfg_we,
  input  logic             cfg_sel,
  input  logic [CW-1:0]    cfg_ch,
  input  logic [WIDTH-1:0] cfg_wdata,
  output logic             cfg_ready,
  output logic             err_ch
);

  localparam int PW = 2 * WIDTH;
  localparam int SW = 2 * WIDTH + 1;

  localparam logic [CW:0]             CH_LIM  = CHANNELS[CW:0];
  localparam logic [CW-1:0]           LAST_CH = CW'(CHANNELS - 1);
  localparam logic signed [WIDTH-1:0] G_ONE   = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;
  localparam logic signed [SW-1:0]    S_ONE   = {{(SW-1){1'b0}}, 1'b1};
  localparam logic signed [SW-1:0]    HALF    = S_ONE << (FRAC - 1);
  localparam logic signed [SW-1:0]    S_MAX   = {{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0]    S_MIN   = {{(WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [SW-1:0]    SIX     = {{(SW-3){1'b0}}, 3'b110} << FRAC;
  localparam logic signed [SW-1:0]    R6_MAX  = (SIX > S_MAX) ? S_MAX : SIX;
  localparam logic signed [WIDTH-1:0] R6_W    = R6_MAX[WIDTH-1:0];
  localparam logic signed [WIDTH-1:0] Y_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] Y_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t state_q, state_d;
  logic [CW-1:0] init_cnt_q, init_cnt_d;
  logic          err_ch_q, err_ch_d;

  logic signed [WIDTH-1:0] gamma_q [CHANNELS];
  logic signed [WIDTH-1:0] beta_q  [CHANNELS];

  logic                    gamma_we, beta_we, cfg_err;
  logic [CW-1:0]           mem_idx;
  logic signed [WIDTH-1:0] gamma_wdata, beta_wdata;

  logic                    s1_valid_q, s1_valid_d;
  logic signed [WIDTH-1:0] s1_x_q, s1_x_d, s1_gamma_q, s1_gamma_d, s1_beta_q, s1_beta_d;
  logic [CW-1:0]           s1_ch_q, s1_ch_d;
  logic [1:0]              s1_act_q, s1_act_d;

  logic                    s2_valid_q, s2_valid_d;
  logic signed [PW-1:0]    s2_prod_q, s2_prod_d;
  logic signed [WIDTH-1:0] s2_beta_q, s2_beta_d;
  logic [CW-1:0]           s2_ch_q, s2_ch_d;
  logic [1:0]              s2_act_q, s2_act_d;

  logic                    out_valid_q, out_valid_d;
  logic [WIDTH-1:0]        out_data_q, out_data_d;
  logic [CW-1:0]           out_ch_q, out_ch_d;

  logic                    adv, in_xfer, in_ch_bad, cfg_ch_bad;
  logic [CW-1:0]           rd_idx;
  logic signed [SW-1:0]    prod_x, rnd, beta_x, sum;
  logic signed [WIDTH-1:0] y;

  assign adv        = !out_valid_q || out_ready;
  assign in_ch_bad  = {1'b0, in_ch} >= CH_LIM;
  assign cfg_ch_bad = {1'b0, cfg_ch} >= CH_LIM;
  assign in_ready   = (state_q == ST_RUN) && adv;
  assign in_xfer    = in_valid && in_ready;
  assign rd_idx     = in_ch_bad ? '0 : in_ch;

  assign cfg_ready  = (state_q == ST_RUN);
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_ch     = out_ch_q;
  assign err_ch     = err_ch_q;

  // INIT sweeps unity parameters into every channel, then RUN accepts runtime writes
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    gamma_we    = 1'b0;
    beta_we     = 1'b0;
    cfg_err     = 1'b0;
    mem_idx     = init_cnt_q;
    gamma_wdata = G_ONE;
    beta_wdata  = '0;
    case (state_q)
      ST_INIT: begin
        gamma_we   = !rst;
        beta_we    = !rst;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == LAST_CH) state_d = ST_RUN;
      end
      default: begin
        if (cfg_we) begin
          if (cfg_ch_bad) begin
            cfg_err = 1'b1;
          end else begin
            mem_idx     = cfg_ch;
            gamma_wdata = cfg_wdata;
            beta_wdata  = cfg_wdata;
            gamma_we    = !rst && !cfg_sel;
            beta_we     = !rst && cfg_sel;
          end
        end
      end
    endcase
  end

  // Parameter tables are written at the clock edge, so same-cycle readers see the old value
  always_ff @(posedge clk) begin
    if (gamma_we) gamma_q[mem_idx] <= gamma_wdata;
    if (beta_we)  beta_q[mem_idx]  <= beta_wdata;
  end

  // Output stage arithmetic: round half up, add beta, saturate, then apply activation
  always_comb begin
    prod_x = {s2_prod_q[PW-1], s2_prod_q};
    rnd    = (prod_x + HALF) >>> FRAC;
    beta_x = {{(WIDTH+1){s2_beta_q[WIDTH-1]}}, s2_beta_q};
    sum    = rnd + beta_x;
    if (sum > S_MAX)      y = Y_MAX;
    else if (sum < S_MIN) y = Y_MIN;
    else                  y = sum[WIDTH-1:0];
    if ((s2_act_q == 2'd1 || s2_act_q == 2'd2) && y < 0) y = '0;
    if (s2_act_q == 2'd2 && y > R6_W) y = R6_W;
  end

  // Three-stage pipeline; every stage moves only when the output register can advance
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_x_d      = s1_x_q;
    s1_gamma_d  = s1_gamma_q;
    s1_beta_d   = s1_beta_q;
    s1_ch_d     = s1_ch_q;
    s1_act_d    = s1_act_q;
    s2_valid_d  = s2_valid_q;
    s2_prod_d   = s2_prod_q;
    s2_beta_d   = s2_beta_q;
    s2_ch_d     = s2_ch_q;
    s2_act_d    = s2_act_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    err_ch_d    = err_ch_q | cfg_err | (in_xfer && in_ch_bad);
    if (adv) begin
      s1_valid_d  = in_xfer;
      s2_valid_d  = s1_valid_q;
      out_valid_d = s2_valid_q;
      if (in_xfer) begin
        s1_x_d     = in_data;
        s1_act_d   = in_act;
        s1_ch_d    = in_ch_bad ? '0 : in_ch;
        s1_gamma_d = in_ch_bad ? G_ONE : gamma_q[rd_idx];
        s1_beta_d  = in_ch_bad ? '0 : beta_q[rd_idx];
      end
      if (s1_valid_q) begin
        s2_prod_d = PW'(s1_x_q) * PW'(s1_gamma_q);
        s2_beta_d = s1_beta_q;
        s2_ch_d   = s1_ch_q;
        s2_act_d  = s1_act_q;
      end
      if (s2_valid_q) begin
        out_data_d = y;
        out_ch_d   = s2_ch_q;
      end
    end
  end

  // State, pipeline and sticky-error registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      err_ch_q    <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_x_q      <= '0;
      s1_gamma_q  <= '0;
      s1_beta_q   <= '0;
      s1_ch_q     <= '0;
      s1_act_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_prod_q   <= '0;
      s2_beta_q   <= '0;
      s2_ch_q     <= '0;
      s2_act_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      err_ch_q    <= err_ch_d;
      s1_valid_q  <= s1_valid_d;
      s1_x_q      <= s1_x_d;
      s1_gamma_q  <= s1_gamma_d;
      s1_beta_q   <= s1_beta_d;
      s1_ch_q     <= s1_ch_d;
      s1_act_q    <= s1_act_d;
      s2_valid_q  <= s2_valid_d;
      s2_prod_q   <= s2_prod_d;
      s2_beta_q   <= s2_beta_d;
      s2_ch_q     <= s2_ch_d;
      s2_act_q    <= s2_act_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

endmodule

// File: tb/tb_batchnorm_stream.sv
// tb/tb_batchnorm_stream.sv - scoreboard bench for batchnorm_stream
module tb_batchnorm_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [5:0]  in_ch;
  logic [1:0]  in_act;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [5:0]  out_ch;
  logic        cfg_we;
  logic        cfg_sel;
  logic [5:0]  cfg_ch;
  logic [15:0] cfg_wdata;
  logic        cfg_ready;
  logic        err_ch;

  int compared   = 0;
  int mismatched = 0;
  int stall_cnt  = 0;
  bit rand_rdy   = 1'b0;

  logic [21:0]        sb[$];
  logic signed [15:0] g_sh[48];
  logic signed [15:0] b_sh[48];

  logic        prev_stall = 1'b0;
  logic [15:0] prev_data;
  logic [5:0]  prev_ch;

  batchnorm_stream #(.WIDTH(16), .FRAC(8), .CHANNELS(48)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ch(in_ch), .in_act(in_act),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_ch(cfg_ch), .cfg_wdata(cfg_wdata),
    .cfg_ready(cfg_ready), .err_ch(err_ch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic signed [15:0] x, input logic signed [15:0] g,
                                        input logic signed [15:0] b, input logic [1:0] act);
    longint p, r, s;
    p = longint'(x) * longint'(g);
    r = (p + 128) >>> 8;
    s = r + longint'(b);
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    if ((act == 2'd1 || act == 2'd2) && s < 0) s = 0;
    if (act == 2'd2 && s > 1536) s = 1536;
    return s[15:0];
  endfunction

  task automatic shadow_reset();
    for (int i = 0; i < 48; i++) begin
      g_sh[i] = 16'sh0100;
      b_sh[i] = 16'sh0000;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_wait(input logic [15:0] x, input logic [5:0] ch, input logic [1:0] act);
    int n = 0;
    in_valid = 1'b1; in_data = x; in_ch = ch; in_act = act;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      tick();
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic finish_xfer();
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_exp(input logic [15:0] x, input logic [5:0] ch, input logic [1:0] act,
                          input logic [15:0] exp_d, input logic [5:0] exp_c);
    drive_wait(x, ch, act);
    sb.push_back({exp_c, exp_d});
    finish_xfer();
  endtask

  task automatic send_mdl(input logic [15:0] x, input logic [5:0] ch, input logic [1:0] act);
    logic signed [15:0] g, b;
    logic [5:0] c;
    if (ch >= 6'd48) begin g = 16'sh0100; b = 16'sh0000; c = 6'd0; end
    else begin g = g_sh[ch]; b = b_sh[ch]; c = ch; end
    drive_wait(x, ch, act);
    sb.push_back({c, model(x, g, b, act)});
    finish_xfer();
  endtask

  task automatic send_drop(input logic [15:0] x, input logic [5:0] ch);
    drive_wait(x, ch, 2'd0);
    finish_xfer();
  endtask

  task automatic cfg(input logic sel, input logic [5:0] ch, input logic [15:0] v);
    cfg_we = 1'b1; cfg_sel = sel; cfg_ch = ch; cfg_wdata = v;
    tick();
    cfg_we = 1'b0;
    if (ch < 6'd48) begin
      if (sel) b_sh[ch] = v;
      else     g_sh[ch] = v;
    end
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk(tag, n, 48);
    chk({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
    tick();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(tag, sb.size(), 0);
  endtask

  // Output monitor: scoreboard pop on every transfer, stability check while stalled
  always @(negedge clk) begin
    logic [21:0] e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(prev_data));
        chk("stall_ch", 32'(out_ch), 32'(prev_ch));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 32'(out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("out_data", 32'(out_data), 32'(e[15:0]));
          chk("out_ch", 32'(out_ch), 32'(e[21:16]));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_ch    = out_ch;
      if (prev_stall) stall_cnt++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_ch = '0; in_act = '0;
    out_ready = 1'b1; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_ch = '0; cfg_wdata = '0;
    shadow_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_ch", 32'(out_ch), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    chk("rst_err_ch", 32'(err_ch), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_init("init_len");

    send_exp(16'h0300, 6'd5, 2'd0, 16'h0300, 6'd5);
    @(negedge clk); chk("lat_t1", 32'(out_valid), 32'd0);
    @(negedge clk); chk("lat_t2", 32'(out_valid), 32'd0);
    @(negedge clk); chk("lat_t3", 32'(out_valid), 32'd1);
    tick();

    cfg(1'b0, 6'd2, 16'h0180);
    cfg(1'b1, 6'd2, 16'h0080);
    send_exp(16'h0200, 6'd2, 2'd0, 16'h0380, 6'd2);
    cfg(1'b0, 6'd3, 16'h0080);
    send_exp(16'h0001, 6'd3, 2'd0, 16'h0001, 6'd3);
    send_exp(16'hFFFF, 6'd3, 2'd0, 16'h0000, 6'd3);
    cfg(1'b0, 6'd4, 16'h0400);
    send_exp(16'h7000, 6'd4, 2'd0, 16'h7FFF, 6'd4);
    send_exp(16'h9000, 6'd4, 2'd0, 16'h8000, 6'd4);
    send_exp(16'hFF00, 6'd10, 2'd1, 16'h0000, 6'd10);
    send_exp(16'h0800, 6'd10, 2'd2, 16'h0600, 6'd10);
    send_exp(16'hFF00, 6'd10, 2'd2, 16'h0000, 6'd10);
    send_exp(16'hFF00, 6'd10, 2'd3, 16'hFF00, 6'd10);
    cfg(1'b0, 6'd60, 16'h1234);
    chk("cfg_bad_err", 32'(err_ch), 32'd1);
    drain("drain_directed");

    rst = 1'b1;
    tick();
    rst = 1'b0;
    shadow_reset();
    wait_init("init_len_b");
    chk("err_clear", 32'(err_ch), 32'd0);

    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_ch = 6'd7; cfg_wdata = 16'h0200;
    in_valid = 1'b1; in_data = 16'h0100; in_ch = 6'd7; in_act = 2'd0;
    @(negedge clk);
    chk("coll_in_ready", 32'(in_ready), 32'd1);
    sb.push_back({6'd7, 16'h0100});
    tick();
    cfg_we = 1'b0; in_valid = 1'b0; g_sh[7] = 16'sh0200;
    send_exp(16'h0100, 6'd7, 2'd0, 16'h0200, 6'd7);

    for (int c = 8; c < 16; c++) begin
      cfg(1'b0, 6'(c), 16'($urandom_range(0, 65535)));
      cfg(1'b1, 6'(c), 16'($urandom_range(0, 65535)));
    end
    rand_rdy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      send_mdl(16'($urandom_range(0, 65535)), 6'($urandom_range(0, 47)), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) tick();
    end
    rand_rdy = 1'b0;
    drain("drain_random");
    chk("stalls_seen", 32'(stall_cnt != 0), 32'd1);
    chk("err_pre_bad", 32'(err_ch), 32'd0);

    send_exp(16'h1234, 6'd50, 2'd0, 16'h1234, 6'd0);
    drain("drain_bad");
    chk("err_bad_ch", 32'(err_ch), 32'd1);
    send_exp(16'h0100, 6'd5, 2'd0, 16'h0100, 6'd5);
    drain("drain_sticky");
    chk("err_sticky", 32'(err_ch), 32'd1);

    out_ready = 1'b0;
    send_drop(16'h0111, 6'd1);
    send_drop(16'h0222, 6'd2);
    send_drop(16'h0333, 6'd3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_err", 32'(err_ch), 32'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    shadow_reset();
    wait_init("init_len_c");
    send_exp(16'h0200, 6'd2, 2'd0, 16'h0200, 6'd2);
    drain("drain_final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
